cfg_chain_loader: RTL
=====================

# cfg_chain_loader

Host-side configuration controller for the fabric's daisy-chained tile configuration path. It accepts configuration words from a host word stream and serializes them LSB-first onto the first tile's bit-serial config input. It generates the chain start pulse, per-bit valid, and a post-load flush, then reports completion. It sits at the fabric edge and drives `cfg_in_start` / `cfg_bit_in` / `cfg_bit_in_valid` of the first `clb_tile`-style tile in the chain.

## Interface
Parameters:
- `CHAIN_BITS`, default 1024: total configuration bits in the chain; must be ≥ 1.
- `WORD_WIDTH`, default 32: host word width; must be ≥ 2.
- `FLUSH_CYCLES`, default 4: idle cycles after the last bit before `done`; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `crst`  in  1  reset, synchronous, active-high.
- `load_start`  in  1  one-cycle request to begin a load; honoured only in IDLE.
- `load_abort`  in  1  terminates any load in progress.
- `word_data`  in  WORD_WIDTH  configuration word; bit 0 is shifted first.
- `word_valid`  in  1  `word_data` is valid.
- `word_ready`  out  1  loader accepts a word this cycle when `word_valid & word_ready`.
- `cfg_start`  out  1  chain start pulse, to the tile's `cfg_in_start`.
- `cfg_bit`  out  1  serial config bit, to the tile's `cfg_bit_in`.
- `cfg_bit_valid`  out  1  `cfg_bit` is valid, to the tile's `cfg_bit_in_valid`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse on successful completion.
- `bits_sent`  out  clog2(CHAIN_BITS+1)  bits emitted in the current or last load.

## Operation
States and transitions:
- **IDLE:**
  - `load_start` → START; `bits_sent` clears to 0 on this transition.
- **START:**
  - `cfg_start` = 1 for exactly this one cycle.
  - `word_ready` = 1, so the first word can be accepted here.
  - Always → SHIFT.
- **SHIFT:**
  - Holds a WORD_WIDTH shift buffer plus a `buf_full` flag.
  - While `buf_full`: `cfg_bit` = buffer bit 0 and `cfg_bit_valid` = 1. Each cycle the buffer shifts right, `bits_sent` increments, and the in-word index increments.
  - `word_ready` = !`buf_full` OR (the current bit is the last bit of the word AND `bits_sent`+1 < CHAIN_BITS). This gives back-to-back words with no bubble.
  - While `buf_full` = 0, `cfg_bit_valid` = 0 (stall). Input starvation is legal and unbounded.
  - When the bit with `bits_sent` = CHAIN_BITS−1 is emitted → FLUSH. Remaining upper bits of the final word are discarded.
  - Words required = ceil(CHAIN_BITS / WORD_WIDTH). `word_ready` never asserts for an extra word.
- **FLUSH:**
  - `cfg_bit_valid` = 0 and `word_ready` = 0 for FLUSH_CYCLES cycles, then → DONE.
- **DONE:**
  - `done` = 1 for one cycle, then → IDLE.

Precedence and boundary rules:
- `load_abort`, in any non-IDLE state, forces IDLE on the next edge. No `done` is produced, the buffer is emptied, and `bits_sent` holds its value. Abort in IDLE is ignored.
- `crst` takes priority over everything, then `load_abort`, then normal transitions.
- `load_start` outside IDLE is ignored. Simultaneous `load_start` + `load_abort` in IDLE starts a load.
- `cfg_bit` = 0 whenever `cfg_bit_valid` = 0.

## Timing
- All outputs are registered.
- Reset values: state IDLE; `word_ready`, `cfg_start`, `cfg_bit`, `cfg_bit_valid`, `busy`, `done` all 0; `bits_sent` 0; buffer empty.
- `load_start` at edge N → `cfg_start` = 1 and `busy` = 1 in cycle N+1.
- A word accepted at edge M → its bit 0 has `cfg_bit_valid` = 1 in cycle M+1.
- With no stalls, the first bit appears 1 cycle after `cfg_start`. Total cycles from `load_start` to the `done` pulse = 1 + 1 + CHAIN_BITS + FLUSH_CYCLES + 1.
- Throughput: 1 bit/cycle sustained.

## Structure
- Shared defines header holds the state encoding (`CFG_ST_IDLE`..`CFG_ST_DONE`) and the default `CFG_WORD_WIDTH`. This is the same header style as the existing channel/CLB width defines.
- One sub-module, `cfg_piso`: a parallel-in serial-out WORD_WIDTH shifter with `load`, `shift`, `bit0`, and last-bit index output.
- The FSM, bit counter and flush counter stay in the top module.

## Test plan
- **Basic load:** CHAIN_BITS=70, WORD_WIDTH=32, FLUSH_CYCLES=4; 3 words streamed with `word_valid` held high; words 0xA5A5A5A5, 0x0000FFFF, 0xFFFFFFC3. Expect: 70 consecutive valid bits, LSB-first, bits 64..69 = 1,1,0,0,0,0; `word_ready` never high for a 4th word; `done` 77 cycles after `load_start`.
- **Starvation:** same config, `word_valid` dropped for 5 cycles after word 1. Expect: `cfg_bit_valid` = 0 exactly 5 cycles between bits 31 and 32; bit order intact; `done` delayed by 5.
- **Abort:** `load_abort` when `bits_sent` = 40. Expect: IDLE next cycle, `busy` = 0, no `done`, `bits_sent` = 41 held. A new `load_start` then clears it to 0 and completes normally.
- **Reset mid-SHIFT:** `crst` asserted mid-load. Expect: all outputs 0 next cycle and `bits_sent` = 0.
- **Start while busy / exact fit:** `load_start` repeated mid-load is ignored. Separately, CHAIN_BITS=64 consumes exactly 2 words with no discarded bits.
- **Chain check:** drive 2 tile models in series. Expect: the second tile's `cfg_out_start` and bit stream match the bits beyond tile 0's share.

Source files
------------

// File: rtl/cfg_chain_loader_pkg.sv
// ============================================================================
// Module   : cfg_chain_loader_pkg
// Brief    : State encoding and shared width defaults for the config loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cfg_chain_loader_pkg;

    localparam int CFG_WORD_WIDTH = 32;

    localparam logic [2:0] CFG_ST_IDLE  = 3'd0;
    localparam logic [2:0] CFG_ST_START = 3'd1;
    localparam logic [2:0] CFG_ST_SHIFT = 3'd2;
    localparam logic [2:0] CFG_ST_FLUSH = 3'd3;
    localparam logic [2:0] CFG_ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = CFG_ST_IDLE,
        ST_START = CFG_ST_START,
        ST_SHIFT = CFG_ST_SHIFT,
        ST_FLUSH = CFG_ST_FLUSH,
        ST_DONE  = CFG_ST_DONE
    } cfg_state_e;

endpackage

`default_nettype wire

// File: rtl/cfg_piso.sv
// ============================================================================
// Module   : cfg_piso
// Brief    : Parallel-in serial-out word shifter, LSB first, zero-filling.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cfg_piso
    import cfg_chain_loader_pkg::*;
#(
    parameter int WORD_WIDTH = CFG_WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clear,
    input  logic                  load,
    input  logic                  shift,
    input  logic [WORD_WIDTH-1:0] i_data,
    output logic                  bit0,
    output logic                  o_full,
    output logic                  o_full_nxt,
    output logic                  o_last_nxt
);

    localparam int c_idx_w = $clog2(WORD_WIDTH);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(WORD_WIDTH - 1);
    localparam logic [c_idx_w-1:0] c_idx_pen  = c_idx_w'(WORD_WIDTH - 2);

    logic [WORD_WIDTH-1:0] r_shreg;
    logic [c_idx_w-1:0]    r_idx;
    logic                  r_full;

    // Look-ahead of the flags so the parent can register its handshake.
    always_comb begin
        o_full_nxt = r_full;
        o_last_nxt = (r_idx == c_idx_last);
        if (i_clear) begin
            o_full_nxt = 1'b0;
            o_last_nxt = 1'b0;
        end else if (load) begin
            o_full_nxt = 1'b1;
            o_last_nxt = 1'b0;
        end else if (shift) begin
            o_full_nxt = (r_idx != c_idx_last);
            o_last_nxt = (r_idx == c_idx_pen);
        end
    end

    // Zero fill keeps bit0 low whenever the buffer holds no valid data.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_shreg <= '0;
            r_idx   <= '0;
        end else if (load) begin
            r_shreg <= i_data;
            r_idx   <= '0;
        end else if (shift) begin
            r_shreg <= r_shreg >> 1;
            r_idx   <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
        end
        r_full <= rst ? 1'b0 : o_full_nxt;
    end

    assign bit0   = r_shreg[0];
    assign o_full = r_full;

endmodule

`default_nettype wire

// File: rtl/cfg_chain_loader.sv
// ============================================================================
// Module   : cfg_chain_loader
// Brief    : Streams host config words LSB-first into a daisy-chained fabric.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cfg_chain_loader
    import cfg_chain_loader_pkg::*;
#(
    parameter int CHAIN_BITS   = 1024,
    parameter int WORD_WIDTH   = CFG_WORD_WIDTH,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic                            clk,
    input  logic                            crst,
    input  logic                            load_start,
    input  logic                            load_abort,
    input  logic [WORD_WIDTH-1:0]           word_data,
    input  logic                            word_valid,
    output logic                            word_ready,
    output logic                            cfg_start,
    output logic                            cfg_bit,
    output logic                            cfg_bit_valid,
    output logic                            busy,
    output logic                            done,
    output logic [$clog2(CHAIN_BITS+1)-1:0] bits_sent
);

    localparam int c_cnt_w   = $clog2(CHAIN_BITS + 1);
    localparam int c_flush_w = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0]   c_last_bit   = c_cnt_w'(CHAIN_BITS - 1);
    localparam logic [c_flush_w-1:0] c_flush_last = c_flush_w'(FLUSH_CYCLES - 1);

    cfg_state_e           r_state;
    cfg_state_e           w_state_nxt;
    logic [c_cnt_w-1:0]   r_bits_sent;
    logic [c_cnt_w-1:0]   w_bits_nxt;
    logic [c_flush_w-1:0] r_flush_cnt;
    logic                 r_word_ready;
    logic                 r_cfg_start;
    logic                 r_busy;
    logic                 r_done;

    logic w_accept;
    logic w_emit;
    logic w_load;
    logic w_clear;
    logic w_full;
    logic w_full_nxt;
    logic w_last_nxt;
    logic w_ready_nxt;

    assign w_accept = word_valid & r_word_ready;
    assign w_emit   = (r_state == ST_SHIFT) & w_full;
    assign w_clear  = (w_state_nxt != ST_SHIFT);
    assign w_load   = w_accept & ~w_clear;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (load_start) w_state_nxt = ST_START;
            ST_START: w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_emit && (r_bits_sent == c_last_bit)) w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (r_flush_cnt == c_flush_last) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (load_abort && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // A bit emitted in the abort cycle still counts.
    always_comb begin
        w_bits_nxt = r_bits_sent;
        if ((r_state == ST_IDLE) && load_start) begin
            w_bits_nxt = '0;
        end else if (w_emit) begin
            w_bits_nxt = r_bits_sent + 1'b1;
        end
    end

    // Ready on the last bit of a word only if another word is still needed.
    always_comb begin
        w_ready_nxt = (w_state_nxt == ST_START) ||
                      ((w_state_nxt == ST_SHIFT) &&
                       (!w_full_nxt || (w_last_nxt && (w_bits_nxt < c_last_bit))));
    end

    always_ff @(posedge clk) begin
        if (crst) begin
            r_state      <= ST_IDLE;
            r_bits_sent  <= '0;
            r_flush_cnt  <= '0;
            r_word_ready <= 1'b0;
            r_cfg_start  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bits_sent  <= w_bits_nxt;
            r_flush_cnt  <= (r_state == ST_FLUSH) ? r_flush_cnt + 1'b1 : '0;
            r_word_ready <= w_ready_nxt;
            r_cfg_start  <= (w_state_nxt == ST_START);
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_done       <= (w_state_nxt == ST_DONE);
        end
    end

    cfg_piso #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_piso (
        .clk        (clk),
        .rst        (crst),
        .i_clear    (w_clear),
        .load       (w_load),
        .shift      (w_emit),
        .i_data     (word_data),
        .bit0       (cfg_bit),
        .o_full     (w_full),
        .o_full_nxt (w_full_nxt),
        .o_last_nxt (w_last_nxt)
    );

    assign cfg_bit_valid = w_full;
    assign word_ready    = r_word_ready;
    assign cfg_start     = r_cfg_start;
    assign busy          = r_busy;
    assign done          = r_done;
    assign bits_sent     = r_bits_sent;

endmodule

`default_nettype wire
